// File: rtl/tetris_button_ctrl.sv
// tetris_button_ctrl: sync, debounce and one-shot/auto-repeat press events
// for the game buttons, held in sticky flags until the consumer acks them.
module tetris_button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 20000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_lvl,
  output logic [4:0] evt,
  input  logic [4:0] evt_ack
);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_e;

  localparam logic [CNT_W-1:0] DEB_END = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_END = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_END = CNT_W'(REPEAT_PERIOD - 1);

  logic [4:0]       s1_q;
  logic [4:0]       sync_q;
  logic [4:0]       lvl_q;
  logic [4:0]       lvl_d;
  logic [4:0]       lvl_dly_q;
  logic [4:0]       evt_q;
  logic [4:0]       evt_d;
  logic [CNT_W-1:0] db_cnt_q [5];
  logic [CNT_W-1:0] db_cnt_d [5];
  rpt_e             st_q [3];
  rpt_e             st_d [3];
  logic [CNT_W-1:0] rp_cnt_q [3];
  logic [CNT_W-1:0] rp_cnt_d [3];
  logic [2:0]       mv_lvl;
  logic [2:0]       mv_rise;
  logic [2:0]       mv_pulse;
  logic [4:0]       rise;
  logic [4:0]       press;
  logic             both_lr;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      sync_q    <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      evt_q     <= '0;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= '0;
      for (int j = 0; j < 3; j++) begin
        st_q[j]     <= IDLE;
        rp_cnt_q[j] <= '0;
      end
    end else begin
      s1_q      <= btn_raw;
      sync_q    <= s1_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      evt_q     <= evt_d;
      for (int i = 0; i < 5; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int j = 0; j < 3; j++) begin
        st_q[j]     <= st_d[j];
        rp_cnt_q[j] <= rp_cnt_d[j];
      end
    end
  end

  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 5; i++) begin
      db_cnt_d[i] = '0;
      if (sync_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DEB_END) lvl_d[i] = sync_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  assign rise    = lvl_q & ~lvl_dly_q;
  assign mv_lvl  = {lvl_q[3], lvl_q[1], lvl_q[0]};
  assign mv_rise = {rise[3], rise[1], rise[0]};

  // Movement keys: index 0 = left, 1 = right, 2 = down
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      st_d[j]     = st_q[j];
      rp_cnt_d[j] = rp_cnt_q[j];
      mv_pulse[j] = 1'b0;
      case (st_q[j])
        IDLE: begin
          if (mv_rise[j]) begin
            mv_pulse[j] = 1'b1;
            rp_cnt_d[j] = '0;
            st_d[j]     = DELAY;
          end
        end
        DELAY: begin
          if (!mv_lvl[j]) begin
            st_d[j] = IDLE;
          end else if (rp_cnt_q[j] == DLY_END) begin
            mv_pulse[j] = 1'b1;
            rp_cnt_d[j] = '0;
            st_d[j]     = REPEAT;
          end else begin
            rp_cnt_d[j] = rp_cnt_q[j] + 1'b1;
          end
        end
        REPEAT: begin
          if (!mv_lvl[j]) begin
            st_d[j] = IDLE;
          end else if (rp_cnt_q[j] == PER_END) begin
            mv_pulse[j] = 1'b1;
            rp_cnt_d[j] = '0;
          end else begin
            rp_cnt_d[j] = rp_cnt_q[j] + 1'b1;
          end
        end
        default: st_d[j] = IDLE;
      endcase
    end
  end

  // Left+right held together cancel each other; FSMs keep their timing
  assign both_lr = lvl_q[0] & lvl_q[1];
  assign press   = {rise[4], mv_pulse[2], rise[2],
                    mv_pulse[1] & ~both_lr,
                    mv_pulse[0] & ~both_lr};

  assign evt_d   = press | (evt_q & ~evt_ack);
  assign btn_lvl = lvl_q;
  assign evt     = evt_q;

endmodule

// File: tb/tb_tetris_button_ctrl.sv
// tb_tetris_button_ctrl: directed checks of debounce, repeat, conflict
// and sticky event flags with small timing parameters.
module tb_tetris_button_ctrl;

  logic       CLK;
  logic       rst_n;
  logic [4:0] btn_raw;
  logic [4:0] btn_lvl;
  logic [4:0] evt;
  logic [4:0] evt_ack;

  int checks = 0;
  int errors = 0;

  tetris_button_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .CNT_W          (25)
  ) dut (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .btn_raw(btn_raw),
    .btn_lvl(btn_lvl),
    .evt    (evt),
    .evt_ack(evt_ack)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic cleanup();
    btn_raw = '0;
    tick(12);
    evt_ack = 5'h1F;
    tick(1);
    evt_ack = '0;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    btn_raw = '0;
    evt_ack = '0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    checks++;
    if (btn_lvl !== 5'h00) begin
      errors++;
      $display("FAIL reset_lvl got %h exp %h", btn_lvl, 5'h00);
    end
    checks++;
    if (evt !== 5'h00) begin
      errors++;
      $display("FAIL reset_evt got %h exp %h", evt, 5'h00);
    end
    btn_raw = 5'h1F;
    tick(7);
    checks++;
    if (btn_lvl !== 5'h1F) begin
      errors++;
      $display("FAIL all_lvl got %h exp %h", btn_lvl, 5'h1F);
    end
    checks++;
    if (evt !== 5'h1C) begin
      errors++;
      $display("FAIL all_evt got %h exp %h", evt, 5'h1C);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (btn_lvl !== 5'h00 || evt !== 5'h00) begin
      errors++;
      $display("FAIL async_rst got %h/%h exp 00/00", btn_lvl, evt);
    end
    tick(3);
    checks++;
    if (btn_lvl !== 5'h00 || evt !== 5'h00) begin
      errors++;
      $display("FAIL held_rst got %h/%h exp 00/00", btn_lvl, evt);
    end
    btn_raw = '0;
    rst_n   = 1'b1;
    tick(10);
  endtask

  task automatic test_clean_press();
    btn_raw[2] = 1'b1;
    tick(5);
    checks++;
    if (btn_lvl[2] !== 1'b0) begin
      errors++;
      $display("FAIL press_early got %b exp 0", btn_lvl[2]);
    end
    tick(1);
    checks++;
    if (btn_lvl[2] !== 1'b1 || evt[2] !== 1'b0) begin
      errors++;
      $display("FAIL press_lvl got %b/%b exp 1/0", btn_lvl[2], evt[2]);
    end
    tick(1);
    checks++;
    if (evt !== 5'h04) begin
      errors++;
      $display("FAIL press_evt got %h exp %h", evt, 5'h04);
    end
    evt_ack[2] = 1'b1;
    tick(1);
    evt_ack[2] = 1'b0;
    checks++;
    if (evt[2] !== 1'b0) begin
      errors++;
      $display("FAIL press_ack got %b exp 0", evt[2]);
    end
    tick(10);
    checks++;
    if (evt !== 5'h00) begin
      errors++;
      $display("FAIL press_norpt got %h exp %h", evt, 5'h00);
    end
    btn_raw[2] = 1'b0;
    tick(8);
    checks++;
    if (btn_lvl !== 5'h00 || evt !== 5'h00) begin
      errors++;
      $display("FAIL press_rel got %h/%h exp 00/00", btn_lvl, evt);
    end
    cleanup();
  endtask

  task automatic test_glitch();
    logic seen_lvl;
    logic seen_evt;
    seen_lvl   = 1'b0;
    seen_evt   = 1'b0;
    btn_raw[4] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 3) btn_raw[4] = 1'b0;
      seen_lvl |= btn_lvl[4];
      seen_evt |= evt[4];
    end
    checks++;
    if (seen_lvl !== 1'b0) begin
      errors++;
      $display("FAIL glitch_lvl got %b exp 0", seen_lvl);
    end
    checks++;
    if (seen_evt !== 1'b0) begin
      errors++;
      $display("FAIL glitch_evt got %b exp 0", seen_evt);
    end
    cleanup();
  endtask

  task automatic test_auto_repeat();
    int got[$];
    int exp_t[4];
    exp_t = '{7, 17, 20, 23};
    btn_raw[3] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      evt_ack = '0;
      if (evt[3]) begin
        got.push_back(k);
        evt_ack[3] = 1'b1;
      end
      if (k == 18) btn_raw[3] = 1'b0;
    end
    evt_ack = '0;
    checks++;
    if (got.size() !== 4) begin
      errors++;
      $display("FAIL rpt_count got %0d exp %0d", got.size(), 4);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_t[i]) begin
          errors++;
          $display("FAIL rpt_time%0d got %0d exp %0d", i, got[i], exp_t[i]);
        end
      end
    end
    checks++;
    if (btn_lvl[3] !== 1'b0) begin
      errors++;
      $display("FAIL rpt_rel got %b exp 0", btn_lvl[3]);
    end
    cleanup();
  endtask

  task automatic test_conflict();
    int got0[$];
    int got1[$];
    int exp0[7];
    exp0 = '{7, 17, 20, 23, 26, 47, 50};
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 51; k++) begin
      tick(1);
      evt_ack = evt & 5'h03;
      if (evt[0]) got0.push_back(k);
      if (evt[1]) got1.push_back(k);
      if (k == 20) btn_raw[1] = 1'b1;
      if (k == 40) btn_raw[1] = 1'b0;
    end
    evt_ack = '0;
    checks++;
    if (got1.size() !== 0) begin
      errors++;
      $display("FAIL conf_right got %0d exp %0d", got1.size(), 0);
    end
    checks++;
    if (got0.size() !== 7) begin
      errors++;
      $display("FAIL conf_left_n got %0d exp %0d", got0.size(), 7);
    end
    for (int i = 0; i < 7; i++) begin
      if (i < got0.size()) begin
        checks++;
        if (got0[i] !== exp0[i]) begin
          errors++;
          $display("FAIL conf_left%0d got %0d exp %0d", i, got0[i], exp0[i]);
        end
      end
    end
    cleanup();
  endtask

  task automatic test_collision();
    btn_raw[0] = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      if (k == 16) begin
        checks++;
        if (evt[0] !== 1'b1) begin
          errors++;
          $display("FAIL coll_pre got %b exp 1", evt[0]);
        end
        evt_ack[0] = 1'b1;
      end
      if (k == 17) begin
        checks++;
        if (evt[0] !== 1'b1) begin
          errors++;
          $display("FAIL coll_set got %b exp 1", evt[0]);
        end
      end
      if (k == 18) begin
        evt_ack[0] = 1'b0;
        checks++;
        if (evt[0] !== 1'b0) begin
          errors++;
          $display("FAIL coll_ack2 got %b exp 0", evt[0]);
        end
      end
    end
    cleanup();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_auto_repeat();
    test_conflict();
    test_collision();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
